// File: rtl/time_set_control_pkg.sv
// Shared watch definitions: FSM state encoding, display flash-select codes,
// field limits and wrap-around helpers used by the time-setting logic.
package time_set_control_pkg;

   // State encoding doubles as the sel code driven to the display
   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StSetSec  = 2'b01,
      StSetMin  = 2'b10,
      StSetHour = 2'b11
   } state_e;

   // Flash-select codes consumed by the display block
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_SEC  = 2'b01;
   localparam logic [1:0] SEL_MIN  = 2'b10;
   localparam logic [1:0] SEL_HOUR = 2'b11;

   // Field limits (inclusive)
   localparam logic [5:0] MAX_SEC  = 6'd59;
   localparam logic [5:0] MAX_MIN  = 6'd59;
   localparam logic [5:0] MAX_HOUR = 6'd23;

   // +1 with wrap max -> 0
   function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
      return (val >= max) ? 6'd0 : val + 6'd1;
   endfunction

   // -1 with wrap 0 -> max
   function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
      return (val == 6'd0) ? max : val - 6'd1;
   endfunction

endpackage

// File: rtl/time_set_control_key_debounce.sv
// Raw key conditioning: 2-flop synchronizer, stability-count debounce and a
// one-cycle pulse on each accepted 0->1 level change.
module key_debounce
   import time_set_control_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            vld1_q, vld1_d;
   logic            vld2_q, vld2_d;
   logic            arm_q, arm_d;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Next-state: synchronize, count stable mismatch cycles, pulse on accepted rise
   always_comb begin
      sync1_d = key_i;
      sync2_d = sync1_q;
      // vld tracks when the synchronizer holds real key samples after reset
      vld1_d  = 1'b1;
      vld2_d  = vld1_q;
      // Arm only once the key has been seen low, so a key held through reset
      // never produces a press when its level is finally accepted
      arm_d   = arm_q | (vld2_q & ~sync2_q);
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
            press_d = sync2_q & arm_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         vld1_q  <= 1'b0;
         vld2_q  <= 1'b0;
         arm_q   <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         vld1_q  <= vld1_d;
         vld2_q  <= vld2_d;
         arm_q   <= arm_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/time_set_control.sv
// Watch time keeping and setting: a 1 s prescaler drives hh:mm:ss in RUN; the
// mode key cycles through seconds/minutes/hours setting, where up/down keys
// adjust only the selected field.
module time_set_control
   import time_set_control_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned TICK_DIV        = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   output logic [5:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic [1:0] sel,
   output logic       tick
);

   localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

   logic mode_press;
   logic up_press;
   logic down_press;
   logic adj_up;
   logic adj_dn;

   state_e            state_q, state_d;
   logic [PrescW-1:0] presc_q, presc_d;
   logic              tick_q, tick_d;
   logic [5:0]        hours_q, hours_d;
   logic [5:0]        mins_q, mins_d;
   logic [5:0]        secs_q, secs_d;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_mode (
      .clk    (clk),
      .reset  (reset),
      .key_i  (key_mode),
      .press_o(mode_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_up (
      .clk    (clk),
      .reset  (reset),
      .key_i  (key_up),
      .press_o(up_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_down (
      .clk    (clk),
      .reset  (reset),
      .key_i  (key_down),
      .press_o(down_press)
   );

   // Simultaneous up and down cancel each other
   assign adj_up = up_press & ~down_press;
   assign adj_dn = down_press & ~up_press;

   // Next-state: mode transitions win over ticks and adjustments
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      hours_d = hours_q;
      mins_d  = mins_q;
      secs_d  = secs_q;
      case (state_q)
         StRun: begin
            if (mode_press) begin
               // A coinciding tick is dropped: the second is not counted
               state_d = StSetSec;
               presc_d = '0;
            end else if (presc_q == PrescMax) begin
               presc_d = '0;
               tick_d  = 1'b1;
               secs_d  = wrap_inc(secs_q, MAX_SEC);
               if (secs_q == MAX_SEC) begin
                  mins_d = wrap_inc(mins_q, MAX_MIN);
                  if (mins_q == MAX_MIN) begin
                     hours_d = wrap_inc(hours_q, MAX_HOUR);
                  end
               end
            end else begin
               presc_d = presc_q + PrescW'(1);
            end
         end
         StSetSec: begin
            presc_d = '0;
            if (mode_press) begin
               state_d = StSetMin;
            end else if (adj_up) begin
               secs_d = wrap_inc(secs_q, MAX_SEC);
            end else if (adj_dn) begin
               secs_d = wrap_dec(secs_q, MAX_SEC);
            end
         end
         StSetMin: begin
            presc_d = '0;
            if (mode_press) begin
               state_d = StSetHour;
            end else if (adj_up) begin
               mins_d = wrap_inc(mins_q, MAX_MIN);
            end else if (adj_dn) begin
               mins_d = wrap_dec(mins_q, MAX_MIN);
            end
         end
         StSetHour: begin
            // Prescaler stays 0 so the first tick after RUN is a full period away
            presc_d = '0;
            if (mode_press) begin
               state_d = StRun;
            end else if (adj_up) begin
               hours_d = wrap_inc(hours_q, MAX_HOUR);
            end else if (adj_dn) begin
               hours_d = wrap_dec(hours_q, MAX_HOUR);
            end
         end
         default: begin
            state_d = StRun;
            presc_d = '0;
         end
      endcase
   end

   // FSM, prescaler and time registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         presc_q <= '0;
         tick_q  <= 1'b0;
         hours_q <= 6'd0;
         mins_q  <= 6'd0;
         secs_q  <= 6'd0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         hours_q <= hours_d;
         mins_q  <= mins_d;
         secs_q  <= secs_d;
      end
   end

   assign hours = hours_q;
   assign mins  = mins_q;
   assign secs  = secs_q;
   assign sel   = state_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_time_set_control.sv
// Directed bench for time_set_control with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_time_set_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_up = 1'b0;
   logic       key_down = 1'b0;
   logic [5:0] hours;
   logic [5:0] mins;
   logic [5:0] secs;
   logic [1:0] sel;
   logic       tick;

   int errors = 0;
   int checks = 0;

   time_set_control #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV       (5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .key_mode(key_mode),
      .key_up  (key_up),
      .key_down(key_down),
      .hours   (hours),
      .mins    (mins),
      .secs    (secs),
      .sel     (sel),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   // Reset for 3 cycles; returns on the falling edge where reset drops
   task automatic apply_reset();
      reset = 1'b1;
      key_mode = 1'b0;
      key_up = 1'b0;
      key_down = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Hold keys 8 cycles (accepted at the 7th edge), then release for 8 cycles
   task automatic press(input logic m, input logic u, input logic d);
      key_mode = m;
      key_up = u;
      key_down = d;
      repeat (8) @(negedge clk);
      key_mode = 1'b0;
      key_up = 1'b0;
      key_down = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({hours, mins, secs} !== 18'd0) begin
         errors++;
         $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hours, mins, secs);
      end
      checks++;
      if (sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_sel: got %0d want 0", sel);
      end
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %0d want 0", tick);
      end
      reset = 1'b0;
   endtask

   // 325 cycles from reset: tick every 5th cycle, 65 s -> 00:01:05
   task automatic test_tick_carry();
      for (int k = 1; k <= 325; k++) begin
         @(negedge clk);
         checks++;
         if (tick !== ((k % 5) == 0)) begin
            errors++;
            $display("FAIL tick_cycle_%0d: got %0d want %0d", k, tick, ((k % 5) == 0));
         end
      end
      checks++;
      if ({hours, mins, secs} !== {6'd0, 6'd1, 6'd5}) begin
         errors++;
         $display("FAIL sec_carry: got %0d:%0d:%0d want 0:1:5", hours, mins, secs);
      end
   endtask

   task automatic test_debounce();
      apply_reset();
      repeat (4) @(negedge clk);
      key_mode = 1'b1;
      repeat (3) @(negedge clk);
      key_mode = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (sel !== 2'd0) begin
         errors++;
         $display("FAIL glitch_ignored: got sel %0d want 0", sel);
      end
      key_mode = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 6) begin
            checks++;
            if (sel !== 2'd0) begin
               errors++;
               $display("FAIL press_early: got sel %0d want 0", sel);
            end
         end
         if (i == 7) begin
            checks++;
            if (sel !== 2'd1) begin
               errors++;
               $display("FAIL press_latency: got sel %0d want 1", sel);
            end
         end
      end
      key_mode = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (sel !== 2'd1) begin
         errors++;
         $display("FAIL press_once: got sel %0d want 1", sel);
      end
   endtask

   // Mode press lands on the edge of the tick that would make 00:00:10
   task automatic test_mode_tick_align();
      apply_reset();
      repeat (43) @(negedge clk);
      key_mode = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (sel !== 2'd1) begin
         errors++;
         $display("FAIL align_sel: got %0d want 1", sel);
      end
      checks++;
      if ({hours, mins, secs} !== {6'd0, 6'd0, 6'd9}) begin
         errors++;
         $display("FAIL align_time: got %0d:%0d:%0d want 0:0:9", hours, mins, secs);
      end
      @(negedge clk);
      key_mode = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_set_wrap();
      repeat (9) press(1'b0, 1'b0, 1'b1);
      checks++;
      if (secs !== 6'd0) begin
         errors++;
         $display("FAIL sec_down_to_0: got %0d want 0", secs);
      end
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if (secs !== 6'd59) begin
         errors++;
         $display("FAIL sec_down_wrap: got %0d want 59", secs);
      end
      press(1'b0, 1'b1, 1'b0);
      checks++;
      if ({hours, mins, secs} !== 18'd0) begin
         errors++;
         $display("FAIL sec_up_wrap: got %0d:%0d:%0d want 0:0:0", hours, mins, secs);
      end
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (sel !== 2'd2) begin
         errors++;
         $display("FAIL sel_min: got %0d want 2", sel);
      end
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if ({hours, mins, secs} !== {6'd0, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL min_down_wrap: got %0d:%0d:%0d want 0:59:59", hours, mins, secs);
      end
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (sel !== 2'd3) begin
         errors++;
         $display("FAIL sel_hour: got %0d want 3", sel);
      end
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if ({hours, mins, secs} !== {6'd23, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL hour_down_wrap: got %0d:%0d:%0d want 23:59:59", hours, mins, secs);
      end
   endtask

   task automatic test_both_keys();
      press(1'b0, 1'b1, 1'b1);
      checks++;
      if ({hours, mins, secs} !== {6'd23, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL both_keys: got %0d:%0d:%0d want 23:59:59", hours, mins, secs);
      end
   endtask

   // SET_HOUR -> RUN; first tick 5 cycles later wraps 23:59:59 to 00:00:00
   task automatic test_return_run();
      key_mode = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 8) key_mode = 1'b0;
         if (i == 7) begin
            checks++;
            if (sel !== 2'd0) begin
               errors++;
               $display("FAIL run_sel: got %0d want 0", sel);
            end
            checks++;
            if ({hours, mins, secs} !== {6'd23, 6'd59, 6'd59}) begin
               errors++;
               $display("FAIL run_entry_time: got %0d:%0d:%0d want 23:59:59", hours, mins, secs);
            end
         end
         if (i >= 7 && i <= 11) begin
            checks++;
            if (tick !== 1'b0) begin
               errors++;
               $display("FAIL run_early_tick_%0d: got %0d want 0", i, tick);
            end
         end
         if (i == 12) begin
            checks++;
            if (tick !== 1'b1) begin
               errors++;
               $display("FAIL run_first_tick: got %0d want 1", tick);
            end
            checks++;
            if ({hours, mins, secs} !== 18'd0) begin
               errors++;
               $display("FAIL day_wrap: got %0d:%0d:%0d want 0:0:0", hours, mins, secs);
            end
         end
      end
   endtask

   // Up press in RUN over 16 cycles: only the 3 ticks change the time
   task automatic test_run_ignore();
      key_up = 1'b1;
      repeat (8) @(negedge clk);
      key_up = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if ({hours, mins, secs} !== {6'd0, 6'd0, 6'd3}) begin
         errors++;
         $display("FAIL run_up_ignored: got %0d:%0d:%0d want 0:0:3", hours, mins, secs);
      end
   endtask

   task automatic test_reset_mid_set();
      apply_reset();
      repeat (4) @(negedge clk);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if ({sel, secs} !== {2'd1, 6'd2}) begin
         errors++;
         $display("FAIL setup_secs: got sel %0d secs %0d want sel 1 secs 2", sel, secs);
      end
      repeat (9) press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      repeat (26) press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      repeat (12) press(1'b0, 1'b1, 1'b0);
      // through RUN (3 ticks: 53 -> 56) back to SET_SEC, then SET_MIN
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if ({sel, hours, mins, secs} !== {2'd2, 6'd12, 6'd34, 6'd56}) begin
         errors++;
         $display("FAIL setup_12_34_56: got sel %0d %0d:%0d:%0d want sel 2 12:34:56",
                  sel, hours, mins, secs);
      end
      key_up = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({sel, tick, hours, mins, secs} !== 21'd0) begin
         errors++;
         $display("FAIL mid_set_reset: got sel %0d tick %0d %0d:%0d:%0d want all 0",
                  sel, tick, hours, mins, secs);
      end
      reset = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if ({sel, hours, mins, secs} !== {2'd0, 6'd0, 6'd0, 6'd2}) begin
         errors++;
         $display("FAIL after_reset_run: got sel %0d %0d:%0d:%0d want sel 0 0:0:2",
                  sel, hours, mins, secs);
      end
      key_up = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Mode key held across reset must not yield a press once accepted
   task automatic test_reset_held_key();
      key_mode = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if (sel !== 2'd0) begin
         errors++;
         $display("FAIL held_key_no_press: got sel %0d want 0", sel);
      end
      key_mode = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (sel !== 2'd0) begin
         errors++;
         $display("FAIL held_key_release: got sel %0d want 0", sel);
      end
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (sel !== 2'd1) begin
         errors++;
         $display("FAIL rearmed_press: got sel %0d want 1", sel);
      end
   endtask

   initial begin
      test_reset();
      test_tick_carry();
      test_debounce();
      test_mode_tick_align();
      test_set_wrap();
      test_both_keys();
      test_return_run();
      test_run_ignore();
      test_reset_mid_set();
      test_reset_held_key();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/time_set_control.md
TIME_SET_CONTROL -- requirements
Module: time_set_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, giving the number of consecutive stable clk cycles required to accept a key level change.
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, giving the number of clk cycles per 1 s tick.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port key_mode, input, 1 bit: raw asynchronous active-high field-select key.
REQ-006 SHALL have port key_up, input, 1 bit: raw asynchronous active-high increment key.
REQ-007 SHALL have port key_down, input, 1 bit: raw asynchronous active-high decrement key.
REQ-008 SHALL have port hours, output, 6 bits: current hours, binary 0..23.
REQ-009 SHALL have port mins, output, 6 bits: current minutes, binary 0..59.
REQ-010 SHALL have port secs, output, 6 bits: current seconds, binary 0..59.
REQ-011 SHALL have port sel, output, 2 bits: field being set (00 none, 01 secs, 10 mins, 11 hours); this is the flash-select code consumed by the display.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse on each counted second.

Function
REQ-013 SHALL pass each raw key through a 2-flop synchronizer before any other use.
REQ-014 SHALL change a key's debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that count.
REQ-015 SHALL generate a one-cycle press pulse in the cycle the debounced level changes 0->1; releases generate nothing.
REQ-016 SHALL implement FSM states RUN, SET_SEC, SET_MIN, SET_HOUR, with sel = 00, 01, 10, 11 respectively, driven directly from the state register.
REQ-017 SHALL advance RUN->SET_SEC->SET_MIN->SET_HOUR->RUN on each mode press.
REQ-018 SHALL, in RUN, increment a prescaler each cycle and assert tick when it equals TICK_DIV-1, then reset the prescaler to 0.
REQ-019 SHALL, on tick, advance the time with carry: secs 59->0 carries to mins, mins 59->0 carries to hours, and 23:59:59 wraps to 00:00:00.
REQ-020 SHALL, in any SET state, hold the prescaler at 0, keep tick low, and freeze all fields except by key action.
REQ-021 SHALL, in SET states, change the selected field by +1 per up press and -1 per down press, wrapping 59<->0 (secs, mins) or 23<->0 (hours) with no carry into other fields.
REQ-022 SHALL update a field in the cycle after its press pulse.
REQ-023 SHALL ignore up and down presses in RUN.
REQ-024 SHALL ignore both up and down when they pulse in the same cycle.
REQ-025 SHALL, when a mode press and a tick coincide in RUN, take the state transition and suppress that tick's time increment.
REQ-026 SHALL, when a mode press and an up/down press coincide in a SET state, take the transition and drop the adjustment.
REQ-027 SHALL restart the prescaler from 0 on SET_HOUR->RUN, so the first tick occurs TICK_DIV cycles later.
REQ-028 SHALL register all outputs, with no combinational path from any key to any output.

Reset
REQ-029 SHALL, on reset, set state RUN, sel 00, hours/mins/secs 0, tick 0, prescaler 0, debounced levels 0, debounce counters 0, and synchronizer flops 0.
REQ-030 SHALL let reset asserted mid-setting or mid-debounce override all activity, with no press pulse generated afterwards from a key level already held high.

Structure
REQ-031 SHALL place the sel encodings (SEL_NONE, SEL_SEC, SEL_MIN, SEL_HOUR) and the constants MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23 in the shared watch package, for reuse by the display block.
REQ-032 SHALL implement synchronize + debounce + rising-edge pulse as one sub-module key_debounce, parameterised by DEBOUNCE_CYCLES and instantiated three times.

Verification
REQ-033 SHALL use bench parameters DEBOUNCE_CYCLES=4 and TICK_DIV=5.
REQ-034 Scenario: reset, then run 5*86400 cycles -> tick every 5th cycle, time reaches 23:59:59 and then 00:00:00.
REQ-035 Scenario: key_mode high for 3 cycles, then low -> no state change; held 8 cycles -> sel becomes 01 exactly once, 2 sync + 4 debounce + 1 cycles after assertion.
REQ-036 Scenario: in SET_SEC with secs=59, one up press -> secs=0, mins unchanged; in SET_HOUR with hours=0, one down press -> hours=23.
REQ-037 Scenario: up and down pressed with the same timing -> no field change; up press in RUN -> no field change.
REQ-038 Scenario: mode press aligned with a tick at 00:00:09 -> sel=01, secs stays 9; three more mode presses -> sel=00, first tick 5 cycles later.
REQ-039 Scenario: reset asserted while in SET_MIN at 12:34:56 with key_up held -> all outputs 0, sel=00, no increment after reset release.
